// File: rtl/alu_seq_pkg.sv
// Shared constants for the nibble-serial ALU sequencer: ALU op codes, FSM
// state encoding and slice width.
package alu_seq_pkg;

    localparam int NIBBLE_W = 4;

    localparam logic [1:0] OP_AND = 2'b00;
    localparam logic [1:0] OP_OR  = 2'b01;
    localparam logic [1:0] OP_XOR = 2'b10;
    localparam logic [1:0] OP_ADD = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } seq_state_e;

    // Carry is only chained through the ALU for ADD; logic ops see carry 0.
    function automatic logic gate_carry(input logic [1:0] op, input logic carry);
        gate_carry = (op == OP_ADD) ? carry : 1'b0;
    endfunction

endpackage

// File: rtl/alu_seq_datapath.sv
// Datapath for alu_nibble_sequencer: operand shift latches, registered ALU
// drive, carry register and result assembly. Optional ALU_SEQ_OVERFLOW_EN.
module alu_seq_datapath
    import alu_seq_pkg::*;
#(
    parameter int W = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                load,
    input  logic                step,
    input  logic                last,
    input  logic [W-1:0]        req_a,
    input  logic [W-1:0]        req_b,
    input  logic [1:0]          req_op,
    input  logic                req_carry_in,
    output logic [NIBBLE_W-1:0] alu_a,
    output logic [NIBBLE_W-1:0] alu_b,
    output logic [1:0]          alu_select,
    output logic                alu_carry_in,
    input  logic [NIBBLE_W-1:0] alu_result,
    input  logic                alu_carry_out,
    output logic [W-1:0]        rsp_result,
    output logic                rsp_carry_out,
    output logic                rsp_zero
`ifdef ALU_SEQ_OVERFLOW_EN
    ,
    output logic                rsp_overflow
`endif
);

    logic [W-1:0]        a_sh_r;
    logic [W-1:0]        b_sh_r;
    logic [1:0]          op_r;
    logic [NIBBLE_W-1:0] alu_a_r;
    logic [NIBBLE_W-1:0] alu_b_r;
    logic [1:0]          alu_sel_r;
    logic                carry_r;
    logic [W-1:0]        res_r;
    logic                rsp_carry_r;
    logic                rsp_zero_r;
    logic [W-1:0]        ins_s;
    logic [W-1:0]        res_nx_s;
    logic                carry_nx_s;

    // Result nibbles enter at the top and shift down, so nibble 0 ends up LSB.
    always_comb begin
        ins_s = '0;
        ins_s[W-1 -: NIBBLE_W] = alu_result;
        res_nx_s   = (res_r >> NIBBLE_W) | ins_s;
        carry_nx_s = gate_carry(op_r, alu_carry_out);
    end

    // Operand latch, ALU drive registers, carry chain and result assembly.
    always_ff @(posedge clk) begin
        if (reset) begin
            a_sh_r      <= '0;
            b_sh_r      <= '0;
            op_r        <= OP_AND;
            alu_a_r     <= 4'h0;
            alu_b_r     <= 4'h0;
            alu_sel_r   <= 2'b00;
            carry_r     <= 1'b0;
            res_r       <= '0;
            rsp_carry_r <= 1'b0;
            rsp_zero_r  <= 1'b1;
        end else if (load) begin
            a_sh_r    <= req_a >> NIBBLE_W;
            b_sh_r    <= req_b >> NIBBLE_W;
            op_r      <= req_op;
            alu_a_r   <= req_a[NIBBLE_W-1:0];
            alu_b_r   <= req_b[NIBBLE_W-1:0];
            alu_sel_r <= req_op;
            carry_r   <= gate_carry(req_op, req_carry_in);
        end else if (step) begin
            res_r  <= res_nx_s;
            a_sh_r <= a_sh_r >> NIBBLE_W;
            b_sh_r <= b_sh_r >> NIBBLE_W;
            if (last) begin
                alu_a_r     <= 4'h0;
                alu_b_r     <= 4'h0;
                alu_sel_r   <= 2'b00;
                carry_r     <= 1'b0;
                rsp_carry_r <= carry_nx_s;
                rsp_zero_r  <= (res_nx_s == '0);
            end else begin
                alu_a_r <= a_sh_r[NIBBLE_W-1:0];
                alu_b_r <= b_sh_r[NIBBLE_W-1:0];
                carry_r <= carry_nx_s;
            end
        end else begin
            res_r <= res_r;
        end
    end

`ifdef ALU_SEQ_OVERFLOW_EN
    logic a_msb_r;
    logic b_msb_r;
    logic ovf_r;

    // Operand sign bits are kept aside because the shift latches lose them.
    always_ff @(posedge clk) begin
        if (reset) begin
            a_msb_r <= 1'b0;
            b_msb_r <= 1'b0;
            ovf_r   <= 1'b0;
        end else if (load) begin
            a_msb_r <= req_a[W-1];
            b_msb_r <= req_b[W-1];
        end else if (step && last) begin
            ovf_r <= (op_r == OP_ADD) && (a_msb_r == b_msb_r)
                     && (alu_result[NIBBLE_W-1] != a_msb_r);
        end else begin
            ovf_r <= ovf_r;
        end
    end

    assign rsp_overflow = ovf_r;
`endif

    assign alu_a         = alu_a_r;
    assign alu_b         = alu_b_r;
    assign alu_select    = alu_sel_r;
    assign alu_carry_in  = carry_r;
    assign rsp_result    = res_r;
    assign rsp_carry_out = rsp_carry_r;
    assign rsp_zero      = rsp_zero_r;

endmodule

// File: rtl/alu_nibble_sequencer.sv
// Runs NIBBLES*4-bit AND/OR/XOR/ADD through a 4-bit ALU one nibble per cycle.
// Optional port rsp_overflow when ALU_SEQ_OVERFLOW_EN is defined.
module alu_nibble_sequencer
    import alu_seq_pkg::*;
#(
    parameter int NIBBLES = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        req_valid,
    output logic                        req_ready,
    input  logic [NIBBLE_W*NIBBLES-1:0] req_a,
    input  logic [NIBBLE_W*NIBBLES-1:0] req_b,
    input  logic [1:0]                  req_op,
    input  logic                        req_carry_in,
    output logic [NIBBLE_W-1:0]         alu_a,
    output logic [NIBBLE_W-1:0]         alu_b,
    output logic [1:0]                  alu_select,
    output logic                        alu_carry_in,
    input  logic [NIBBLE_W-1:0]         alu_result,
    input  logic                        alu_carry_out,
    output logic                        rsp_valid,
    input  logic                        rsp_ready,
    output logic [NIBBLE_W*NIBBLES-1:0] rsp_result,
    output logic                        rsp_carry_out,
    output logic                        rsp_zero
`ifdef ALU_SEQ_OVERFLOW_EN
    ,
    output logic                        rsp_overflow
`endif
);

    localparam int W     = NIBBLE_W * NIBBLES;
    localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NIBBLES - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

    seq_state_e       state_r;
    seq_state_e       state_nx_s;
    logic [IDX_W-1:0] idx_r;
    logic             req_ready_r;
    logic             rsp_valid_r;
    logic             load_s;
    logic             step_s;
    logic             last_s;

    // Next-state and datapath strobes.
    always_comb begin
        state_nx_s = state_r;
        load_s     = 1'b0;
        step_s     = 1'b0;
        last_s     = 1'b0;
        case (state_r)
            IDLE: begin
                if (req_valid) begin
                    state_nx_s = RUN;
                    load_s     = 1'b1;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            RUN: begin
                step_s = 1'b1;
                if (idx_r == IDX_LAST) begin
                    last_s     = 1'b1;
                    state_nx_s = DONE;
                end else begin
                    state_nx_s = RUN;
                end
            end
            DONE: begin
                if (rsp_ready) begin
                    state_nx_s = IDLE;
                end else begin
                    state_nx_s = DONE;
                end
            end
            default: begin
                state_nx_s = IDLE;
            end
        endcase
    end

    // State, nibble index and handshake flags; flags follow the next state so they are registered.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= IDLE;
            idx_r       <= '0;
            req_ready_r <= 1'b1;
            rsp_valid_r <= 1'b0;
        end else begin
            state_r     <= state_nx_s;
            req_ready_r <= (state_nx_s == IDLE);
            rsp_valid_r <= (state_nx_s == DONE);
            if (load_s) begin
                idx_r <= '0;
            end else if (step_s) begin
                idx_r <= idx_r + IDX_ONE;
            end else begin
                idx_r <= idx_r;
            end
        end
    end

    alu_seq_datapath #(
        .W(W)
    ) u_datapath (
        .clk           (clk),
        .reset         (reset),
        .load          (load_s),
        .step          (step_s),
        .last          (last_s),
        .req_a         (req_a),
        .req_b         (req_b),
        .req_op        (req_op),
        .req_carry_in  (req_carry_in),
        .alu_a         (alu_a),
        .alu_b         (alu_b),
        .alu_select    (alu_select),
        .alu_carry_in  (alu_carry_in),
        .alu_result    (alu_result),
        .alu_carry_out (alu_carry_out),
        .rsp_result    (rsp_result),
        .rsp_carry_out (rsp_carry_out),
        .rsp_zero      (rsp_zero)
`ifdef ALU_SEQ_OVERFLOW_EN
        ,
        .rsp_overflow  (rsp_overflow)
`endif
    );

    assign req_ready = req_ready_r;
    assign rsp_valid = rsp_valid_r;

endmodule
